// File: rtl/range_sum_pkg.sv
// -----------------------------------------------------------------------------
// range_sum_pkg
// Shared types and constants for the range-sum scheduler and its engine.
//   state_t     : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   LANES       : number of 4-bit lanes in the engine's input word
//   LANE_W      : width of one lane
//   IDX_W       : width of a lane index (lo/hi bound)
//   SUM_W       : width of a range sum (8 lanes of 4 bits, max 120)
//   DEF_TIMEOUT : default engine-cycle budget per job (timeout build only)
// -----------------------------------------------------------------------------
package range_sum_pkg;

  localparam int LANES       = 8;
  localparam int LANE_W      = 4;
  localparam int IDX_W       = $clog2(LANES);
  localparam int SUM_W       = LANE_W + IDX_W + 1;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/range_sum_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the first set request at or
// above rr_ptr, searching upward and wrapping past NREQ-1 back to 0. The
// pointer register itself lives in the caller.
//   req       : per-requester request vector
//   rr_ptr    : requester with highest priority this cycle
//   grant     : one-hot grant, zero when no request is set
//   grant_idx : encoded grant index (0 when no request is set)
//   any_valid : at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_valid
);

  always_comb begin
    // NOTE: every output gets a default before any conditional write; a path
    // that leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    any_valid = |req;
    // Walk offsets from farthest to nearest so the nearest set request to
    // rr_ptr is the last write and therefore wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NREQ]) begin
        grant                                = '0;
        grant[(int'(rr_ptr) + i) % NREQ]     = 1'b1;
        grant_idx                            = ID_W'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/range_sum_sched.sv
// -----------------------------------------------------------------------------
// range_sum_sched
// Shares one sequential range-sum engine among NREQ requesters. A request
// carries two unordered bounds; the scheduler picks a requester round-robin,
// orders the bounds into lo/hi, pulses eng_start, waits for eng_done and
// returns the engine's sum on a single response channel tagged with the
// requester id. One job is in flight at a time.
//
// Optional build macro: RANGE_SUM_SCHED_TIMEOUT_EN
//   When defined, a job whose engine has not reported done after TIMEOUT
//   WAIT cycles is answered with rsp_err = 1 and rsp_sum = 0. When undefined,
//   WAIT lasts until eng_done and rsp_err is tied to 0.
//
// Ports
//   clk, rst     : clock; asynchronous active-high reset
//   req_valid    : per-requester valid
//   req_ready    : per-requester accept, one-hot or zero, only in IDLE
//   req_bound_a  : packed first bound, requester k at [k*IDX_W +: IDX_W]
//   req_bound_b  : packed second bound, same packing
//   rsp_valid    : response valid, held until rsp_ready
//   rsp_ready    : response accept
//   rsp_id       : requester being answered
//   rsp_sum      : range sum
//   rsp_err      : job aborted by timeout
//   eng_start    : one-cycle start pulse to the engine
//   eng_lo/hi    : ordered bounds, stable from ISSUE through WAIT
//   eng_done     : engine completion pulse
//   eng_sum      : engine result, valid with eng_done
//   busy         : scheduler is not in IDLE
// -----------------------------------------------------------------------------
module range_sum_sched #(
  parameter int  NREQ    = 4,
  parameter int  IDX_W   = range_sum_pkg::IDX_W,
  parameter int  SUM_W   = range_sum_pkg::SUM_W,
  parameter int  TIMEOUT = range_sum_pkg::DEF_TIMEOUT,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*IDX_W-1:0] req_bound_a,
  input  logic [NREQ*IDX_W-1:0] req_bound_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [SUM_W-1:0]      rsp_sum,
  output logic                  rsp_err,
  output logic                  eng_start,
  output logic [IDX_W-1:0]      eng_lo,
  output logic [IDX_W-1:0]      eng_hi,
  input  logic                  eng_done,
  input  logic [SUM_W-1:0]      eng_sum,
  output logic                  busy
);

  import range_sum_pkg::*;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("range_sum_sched: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_valid;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [IDX_W-1:0]   lo_q, hi_q;
  logic [IDX_W-1:0]   a_sel, b_sel;
  logic               rsp_valid_q;
  logic [SUM_W-1:0]   rsp_sum_q;
  logic               hs;
  logic               timeout_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Ready is gated by rst so it reads 0 while reset is held even though the
  // state register already sits in IDLE.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign hs        = |(req_valid & req_ready);

  // Bounds of the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        a_sel = req_bound_a[k*IDX_W +: IDX_W];
        b_sel = req_bound_b[k*IDX_W +: IDX_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT-cycle watchdog
  // ---------------------------------------------------------------------------
`ifdef RANGE_SUM_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;

  // cnt_q is 0 in the first WAIT cycle, so it equals TIMEOUT-1 in the
  // TIMEOUT-th WAIT cycle, which is when the job is abandoned.
  assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;

      // eng_done wins over a coincident timeout.
      if (state_q == WAIT && eng_done) rsp_err_q <= 1'b0;
      else if (timeout_hit)            rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs)                      state_d = ISSUE;
      ISSUE:                                state_d = WAIT;
      WAIT:    if (eng_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
    end else begin
      if (hs) begin
        id_q     <= grant_idx;
        lo_q     <= (a_sel < b_sel) ? a_sel : b_sel;
        hi_q     <= (a_sel < b_sel) ? b_sel : a_sel;
        rr_ptr_q <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      if (state_q == WAIT && eng_done) begin
        rsp_sum_q   <= eng_sum;
        rsp_valid_q <= 1'b1;
      end else if (timeout_hit) begin
        rsp_sum_q   <= '0;
        rsp_valid_q <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = rsp_sum_q;
  assign eng_start = (state_q == ISSUE);
  assign eng_lo    = lo_q;
  assign eng_hi    = hi_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_range_sum_sched.sv
// -----------------------------------------------------------------------------
// tb_range_sum_sched
// Self-checking bench for range_sum_sched with a behavioural range-sum engine
// (latency hi-lo+1 unless overridden). Expected responses and expected engine
// bounds are queued when a grant is observed and compared when the DUT
// produces them. Timeout cases are built only with RANGE_SUM_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_range_sum_sched;

  localparam int NREQ    = 4;
  localparam int IDX_W   = 3;
  localparam int SUM_W   = 8;
  localparam int TIMEOUT = 16;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*IDX_W-1:0] req_bound_a;
  logic [NREQ*IDX_W-1:0] req_bound_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [SUM_W-1:0]      rsp_sum;
  logic                  rsp_err;
  logic                  eng_start;
  logic [IDX_W-1:0]      eng_lo;
  logic [IDX_W-1:0]      eng_hi;
  logic                  eng_done;
  logic [SUM_W-1:0]      eng_sum;
  logic                  busy;

  range_sum_sched #(
    .NREQ(NREQ), .IDX_W(IDX_W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bound_a(req_bound_a), .req_bound_b(req_bound_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_lo(eng_lo), .eng_hi(eng_hi),
    .eng_done(eng_done), .eng_sum(eng_sum), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  typedef struct { logic [1:0] id; logic [SUM_W-1:0] sum; logic err; } rsp_t;
  typedef struct { logic [IDX_W-1:0] lo; logic [IDX_W-1:0] hi; } bnd_t;

  rsp_t exp_q[$];
  bnd_t bnd_q[$];

  // ---------------------------------------------------------------------------
  // Engine model
  // ---------------------------------------------------------------------------
  logic [31:0]      lane_word;
  int               lat_override;
  bit               eng_mute;
  int               eng_cnt;
  logic [SUM_W-1:0] eng_hold;

  function automatic logic [SUM_W-1:0] lane_sum(input logic [31:0] w, input int lo, input int hi);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = lo; k <= hi; k++) s = s + SUM_W'(w[k*4 +: 4]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
      eng_sum  <= '0;
      eng_hold <= '0;
    end else begin
      eng_done <= 1'b0;
      if (eng_start) begin
        eng_cnt  <= (lat_override > 0) ? lat_override : int'(eng_hi) - int'(eng_lo) + 1;
        eng_hold <= lane_sum(lane_word, int'(eng_lo), int'(eng_hi));
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1 && !eng_mute) begin
          eng_done <= 1'b1;
          eng_sum  <= eng_hold;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic prev_start = 1'b0;
  bnd_t mon_b;
  rsp_t mon_r;

  always @(negedge clk) begin
    if (eng_start) begin
      check("start_single_pulse", {31'b0, prev_start}, 0);
      if (bnd_q.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        mon_b = bnd_q.pop_front();
        check("eng_lo", {29'b0, eng_lo}, {29'b0, mon_b.lo});
        check("eng_hi", {29'b0, eng_hi}, {29'b0, mon_b.hi});
      end
    end
    prev_start = eng_start;
  end

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_r = exp_q.pop_front();
        check("rsp_id",  {30'b0, rsp_id},  {30'b0, mon_r.id});
        check("rsp_sum", {24'b0, rsp_sum}, {24'b0, mon_r.sum});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_r.err});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic int bound_of(input logic [NREQ*IDX_W-1:0] v, input int id);
    return int'(v[id*IDX_W +: IDX_W]);
  endfunction

  // Queue the expectations for a job granted to requester id.
  task automatic push_job(input int id, input bit err);
    int a, b, lo, hi;
    rsp_t r;
    bnd_t bd;
    a     = bound_of(req_bound_a, id);
    b     = bound_of(req_bound_b, id);
    lo    = (a < b) ? a : b;
    hi    = (a < b) ? b : a;
    bd.lo = IDX_W'(lo);
    bd.hi = IDX_W'(hi);
    r.id  = 2'(id);
    r.err = err;
    r.sum = err ? '0 : lane_sum(lane_word, lo, hi);
    bnd_q.push_back(bd);
    exp_q.push_back(r);
  endtask

  // Present one request and hold it until granted; returns in the ISSUE cycle.
  task automatic run_job(input int id, input int a, input int b, input bit err);
    bit granted;
    granted = 1'b0;
    @(posedge clk); #1;
    req_bound_a[id*IDX_W +: IDX_W] = IDX_W'(a);
    req_bound_b[id*IDX_W +: IDX_W] = IDX_W'(b);
    req_valid[id] = 1'b1;
    for (int c = 0; c < 200 && !granted; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("req_ready_onehot", {28'b0, req_ready}, 32'(1 << id));
        push_job(id, err);
        granted = 1'b1;
      end
    end
    if (!granted) check("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, {28'b0, req_ready}, 0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
    check({tag, "_rsp_id"},    {30'b0, rsp_id},    0);
    check({tag, "_rsp_sum"},   {24'b0, rsp_sum},   0);
    check({tag, "_rsp_err"},   {31'b0, rsp_err},   0);
    check({tag, "_eng_start"}, {31'b0, eng_start}, 0);
    check({tag, "_eng_lo"},    {29'b0, eng_lo},    0);
    check({tag, "_eng_hi"},    {29'b0, eng_hi},    0);
    check({tag, "_busy"},      {31'b0, busy},      0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  int rot_a[NREQ] = '{1, 6, 2, 7};
  int rot_b[NREQ] = '{4, 3, 2, 0};

  initial begin
    rst          = 1'b1;
    req_valid    = 4'b0001;
    req_bound_a  = '0;
    req_bound_b  = '0;
    rsp_ready    = 1'b1;
    lane_word    = 32'h8765_4321;
    lat_override = 0;
    eng_mute     = 1'b0;

    // Reset state, with a request pending to show ready is held off.
    #12;
    check_all_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // All requesters valid: grants rotate 0,1,2,3 and wrap to 0.
    @(posedge clk); #1;
    for (int k = 0; k < NREQ; k++) begin
      req_bound_a[k*IDX_W +: IDX_W] = IDX_W'(rot_a[k]);
      req_bound_b[k*IDX_W +: IDX_W] = IDX_W'(rot_b[k]);
    end
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      bit got_grant;
      int g;
      got_grant = 1'b0;
      g         = -1;
      for (int c = 0; c < 200 && !got_grant; c++) begin
        @(negedge clk);
        if (req_ready != '0) got_grant = 1'b1;
      end
      if (!got_grant) begin
        check("rr_grant_timeout", 0, 1);
      end else begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
        check("rr_grant_order", 32'(g), 32'(i % NREQ));
        push_job(g, 1'b0);
      end
      @(posedge clk); #1;
      if (i == 4) req_valid = '0;
    end
    wait_idle();

    // Single requester, swapped bounds: lo=2, hi=5, sum 3+4+5+6.
    run_job(0, 5, 2, 1'b0);
    wait_idle();

    // Response backpressure: held stable for 10 cycles, no new grant.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    run_job(1, 4, 1, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      if (!seen) check("bp_rsp_timeout", 0, 1);
    end
    @(posedge clk); #1;
    req_bound_a[2*IDX_W +: IDX_W] = 3'd0;
    req_bound_b[2*IDX_W +: IDX_W] = 3'd7;
    req_valid[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      check("bp_rsp_id",    {30'b0, rsp_id},    1);
      check("bp_rsp_sum",   {24'b0, rsp_sum},   {24'b0, lane_sum(lane_word, 1, 4)});
      check("bp_req_ready", {28'b0, req_ready}, 0);
    end
    // Requester 2 withdraws before ever being granted; it must leave no trace.
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    rsp_ready    = 1'b1;
    wait_idle();

    // Asynchronous reset while the engine is busy.
    lat_override = 30;
    run_job(2, 3, 6, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    bnd_q.delete();
    #20;
    rst          = 1'b0;
    lat_override = 0;

    // Saturated lanes: single lane and full range.
    lane_word = 32'hFFFF_FFFF;
    run_job(3, 7, 7, 1'b0);
    wait_idle();
    run_job(1, 0, 7, 1'b0);
    wait_idle();

`ifdef RANGE_SUM_SCHED_TIMEOUT_EN
    // Engine never answers: aborted in the 16th WAIT cycle.
    lane_word = 32'h8765_4321;
    eng_mute  = 1'b1;
    run_job(3, 1, 6, 1'b1);
    begin
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        n++;
        if (rsp_valid) seen = 1'b1;
      end
      // One ISSUE cycle, sixteen WAIT cycles, then RESP.
      check("timeout_latency", 32'(n), 32'(TIMEOUT + 2));
    end
    wait_idle();
    eng_mute = 1'b0;

    // Done lands in the same cycle as the timeout: done wins.
    lat_override = TIMEOUT - 1;
    run_job(0, 2, 5, 1'b0);
    wait_idle();
    lat_override = 0;
`endif

    check("queue_drained", 32'(exp_q.size() + bnd_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/range_sum_sched.md
Name: range_sum_sched

Overview:
- Scheduler that shares one sequential range-sum engine (sums 4-bit lanes I[lo..hi] of a 32-bit word into an 8-bit result) among NREQ requesters.
- Accepts (M, m) bound pairs per requester, normalises them to lo/hi, and arbitrates round-robin.
- Issues one job at a time to the engine and returns the result, tagged with the requester id, on a single response channel.
- Sits between the request sources and the engine instance in the datapath top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDX_W, 3, bound index width (8 lanes).
- SUM_W, 8, result width.
- TIMEOUT, 16, maximum engine cycles per job (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_bound_a  in  NREQ*IDX_W  packed first bound M; requester k occupies bits [k*IDX_W +: IDX_W]
- req_bound_b  in  NREQ*IDX_W  packed second bound m, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  clog2(NREQ)  index of the requester being answered
- rsp_sum  out  SUM_W  summed result
- rsp_err  out  1  job aborted (timeout); 0 when the feature is off
- eng_start  out  1  one-cycle start pulse to the engine
- eng_lo  out  IDX_W  normalised low bound, held stable from ISSUE through WAIT
- eng_hi  out  IDX_W  normalised high bound, held stable from ISSUE through WAIT
- eng_done  in  1  engine completion pulse
- eng_sum  in  SUM_W  engine result; valid in the eng_done cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; rr_ptr 0; every output 0 (req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, eng_start, eng_lo, eng_hi, busy).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid requester at or after rr_ptr, searching upward with wrap.
  - req_ready[g] is combinationally high for one cycle in IDLE; the handshake is req_valid & req_ready.
  - On the handshake, latch id g, set lo = min(a, b) and hi = max(a, b), set rr_ptr = (g+1) mod NREQ, and go to ISSUE.
  - Requesters must hold valid and bounds until they see ready.
- ISSUE: eng_start = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On eng_done, register rsp_sum = eng_sum, set rsp_err = 0, set rsp_valid = 1, and go to RESP.
  - An eng_done seen in any other state is ignored.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_sum and rsp_err stable until rsp_ready.
  - On rsp_valid & rsp_ready, clear rsp_valid and return to IDLE.
  - A new grant can occur no earlier than the cycle after IDLE is re-entered.
- Throughput: one job in flight. Minimum latency from handshake to rsp_valid is 2 + engine latency cycles.
- Boundary conditions:
  - a == b gives lo == hi, a single-lane job.
  - Bounds 0 and 7 give the full range.
  - With all requesters valid, grants rotate 0, 1, 2, 3, 0, … with no starvation.
  - rr_ptr wraps from NREQ-1 to 0.
  - A requester that drops valid in IDLE before being granted is skipped with no side effect.
- Asynchronous rst mid-job: the FSM returns to IDLE, rsp_valid drops, and eng_start stays 0. The engine is reset by the same rst.

Optional Feature:
- Macro: RANGE_SUM_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT without eng_done, go to RESP with rsp_err = 1 and rsp_sum = 0.
  - eng_done arriving in the same cycle as the timeout takes priority (rsp_err = 0).
- Not defined: no counter is built, WAIT lasts indefinitely, and rsp_err is tied to 0.

Decomposition:
- Package range_sum_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Constants LANES = 8, LANE_W = 4, IDX_W = 3, SUM_W = 8.
  - Default TIMEOUT.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded grant index, any_valid.
  - Purely combinational; rr_ptr stays in range_sum_sched.

Test Plan:
- Requester 0 only, a=5, b=2, engine model with I = 32'h87654321 (latency hi-lo+1) -> eng_lo=2, eng_hi=5, eng_start pulses once, rsp_id=0, rsp_sum=3+4+5+6=18.
- Requesters 0–3 valid continuously with differing bounds -> grant order 0,1,2,3,0; each rsp_id matches the correct sum; eng_start is never asserted while busy is in WAIT.
- a=b=7, and separately a=0, b=7 with I = 32'hFFFFFFFF -> rsp_sum=15, and rsp_sum=120 respectively.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_sum stay stable, and req_ready stays 0 throughout.
- rst asserted during WAIT -> all outputs 0 asynchronously, state IDLE; a new request afterwards completes normally.
- With RANGE_SUM_SCHED_TIMEOUT_EN and TIMEOUT=16, engine never returns done -> rsp_valid with rsp_err=1, rsp_sum=0 on the 16th WAIT cycle; a subsequent job with done on that cycle gives rsp_err=0.
